prbs_checker_s: RTL



---
 rtl/prbs_checker_s_pkg.sv | 32 +++
 rtl/prbs_checker_s_if.sv | 40 ++++
 rtl/prbs_checker_s_sat_counter.sv | 23 ++
 rtl/prbs_checker_s.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_checker_s_pkg.sv
// Shared types and helpers for the serial PRBS checker.
// Optional feature macro: PRBS_CHK_BITCNT_EN (adds bit_cnt output).
package prbs_pkg;

  // Widest LFSR order poly_rev can handle.
  localparam int unsigned PRBS_MAX_W = 64;

  // Default x^16 + x^14 + x^13 + x^11 + 1 feedback taps (x^16 implicit).
  localparam logic [15:0] PRBS16_POLY = 16'h6801;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } prbs_chk_state_e;

  // Bit-reverse the low 'width' bits of poly; bits at or above width are 0.
  function automatic logic [PRBS_MAX_W-1:0] poly_rev(
    input logic [PRBS_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [PRBS_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < PRBS_MAX_W; i++) begin
      if (i < width) begin
        r[i] = poly[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_checker_s_if.sv
// Serial data / status bundle between a PRBS source and the checker.
// Optional feature macro: PRBS_CHK_BITCNT_EN (adds bit_cnt).
interface prbs_checker_s_if #(
  parameter int unsigned CNT_W = 32
);

  logic             din;
  logic             din_vld;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic             lock_lost;
`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt;
`endif

`ifdef PRBS_CHK_BITCNT_EN
  modport master (
    output din, din_vld, clr,
    input  locked, err_pulse, err_cnt, lock_lost, bit_cnt
  );

  modport slave (
    input  din, din_vld, clr,
    output locked, err_pulse, err_cnt, lock_lost, bit_cnt
  );
`else
  modport master (
    output din, din_vld, clr,
    input  locked, err_pulse, err_cnt, lock_lost
  );

  modport slave (
    input  din, din_vld, clr,
    output locked, err_pulse, err_cnt, lock_lost
  );
`endif

endinterface

// File: rtl/prbs_checker_s_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clr zeroes unconditionally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker_s.sv
// Self-synchronising serial PRBS checker for a Galois LFSR source.
// Seeds its history from the received stream, verifies LOCK_CNT bits,
// then flywheels its own prediction and counts mismatches.
// Optional feature macro: PRBS_CHK_BITCNT_EN (saturating bit_cnt while LOCKED).
module prbs_checker_s
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(PRBS16_POLY),
  parameter int unsigned      LOCK_CNT    = 16,
  parameter int unsigned      WINDOW      = 256,
  parameter int unsigned      LOSS_THRESH = 8,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  prbs_checker_s_if.slave bus
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WBIT_W  = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  // hist[0] is the newest bit, so the taps are the reversed polynomial.
  localparam logic [WIDTH-1:0] POLY_REV =
    WIDTH'(poly_rev(PRBS_MAX_W'(POLY), WIDTH));

  prbs_chk_state_e      state_q, state_d;
  logic [WIDTH-1:0]     hist_q, hist_d;
  logic [FILL_W-1:0]    fill_cnt_q;
  logic [MATCH_W-1:0]   match_cnt_q;
  logic [WBIT_W-1:0]    win_bits_q;
  logic [WERR_W-1:0]    win_err_q;

  logic                 accept;
  logic                 pred;
  logic                 mismatch;
  logic                 bit_in;
  logic                 win_end;
  logic                 err_evt;
  logic                 loss_evt;
  logic                 stay_search;
  logic                 stay_verify;
  logic                 stay_locked;

  logic                 locked_o;
  logic                 err_pulse_q;
  logic                 lock_lost_q;
  logic [CNT_W-1:0]     err_cnt;

  assign accept   = bus.din_vld;
  assign pred     = ^(hist_q & POLY_REV);
  assign mismatch = bus.din ^ pred;
  // While locked the history follows the prediction, so line errors
  // never feed back into later predictions.
  assign bit_in   = (state_q == LOCKED) ? pred : bus.din;
  assign hist_d   = {hist_q[WIDTH-2:0], bit_in};
  assign win_end  = (win_bits_q == WBIT_W'(WINDOW - 1));

  assign stay_search = (state_q == SEARCH) && (state_d == SEARCH);
  assign stay_verify = (state_q == VERIFY) && (state_d == VERIFY);
  assign stay_locked = (state_q == LOCKED) && (state_d == LOCKED);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-bit error / loss-of-lock events.
  always_comb begin
    state_d  = state_q;
    err_evt  = 1'b0;
    loss_evt = 1'b0;
    if (accept) begin
      case (state_q)
        SEARCH: begin
          if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            state_d = SEARCH;
          end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
            // An all-zero seed predicts zeros forever; refuse to lock on it.
            state_d = (hist_d == '0) ? SEARCH : LOCKED;
          end
        end
        LOCKED: begin
          err_evt = mismatch;
          // Loss check uses the pre-reset window count, so it wins over
          // a coincident end-of-window restart.
          if (mismatch && (win_err_q == WERR_W'(LOSS_THRESH - 1))) begin
            loss_evt = 1'b1;
            state_d  = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // History, seeding and window counters advance only on accepted bits.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
    end else if (accept) begin
      hist_q      <= hist_d;
      fill_cnt_q  <= stay_search ? fill_cnt_q + FILL_W'(1) : '0;
      match_cnt_q <= stay_verify ? match_cnt_q + MATCH_W'(1) : '0;
      if (stay_locked) begin
        win_bits_q <= win_end ? '0 : win_bits_q + WBIT_W'(1);
        win_err_q  <= win_end ? '0 : win_err_q + WERR_W'(err_evt);
      end else begin
        win_bits_q <= '0;
        win_err_q  <= '0;
      end
    end
  end

  // Registered error pulse and sticky loss-of-lock flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      err_pulse_q <= err_evt;
      if (bus.clr) begin
        lock_lost_q <= 1'b0;
      end else if (loss_evt) begin
        lock_lost_q <= 1'b1;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    locked_o = (state_q == LOCKED);
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (err_evt),
    .clr   (bus.clr),
    .cnt   (err_cnt)
  );

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt;

  sat_counter #(
    .W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (accept && (state_q == LOCKED)),
    .clr   (bus.clr),
    .cnt   (bit_cnt)
  );

  assign bus.bit_cnt = bit_cnt;
`endif

  assign bus.locked    = locked_o;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt;
  assign bus.lock_lost = lock_lost_q;

endmodule
